// File: rtl/ps2_paddle_keys.sv
// Set-2 scancode key-state tracker for the four paddle keys (W/S/O/K).
// Decodes make / F0 break / E0 extended prefixes. Includes a stuck-key idle timeout.
module ps2_paddle_keys #(
  parameter logic [7:0] KEY_W       = 8'h1D,
  parameter logic [7:0] KEY_S       = 8'h1B,
  parameter logic [7:0] KEY_O       = 8'h44,
  parameter logic [7:0] KEY_K       = 8'h42,
  parameter int         TIMEOUT_CYC = 25_000_000,
  parameter int         TW          = 25
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] key_data,
  input  logic       key_pressed,
  output logic       w_on,
  output logic       s_on,
  output logic       o_on,
  output logic       k_on,
  output logic       key_evt,
  output logic [7:0] last_code
);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  localparam logic [7:0]    CODE_BRK  = 8'hF0;
  localparam logic [7:0]    CODE_EXT  = 8'hE0;
  localparam logic [31:0]   KEY_CODES = {KEY_K, KEY_O, KEY_S, KEY_W};
  localparam bit            TO_EN     = (TIMEOUT_CYC > 0);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYC);

  state_t        state_reg, state_next;
  logic [3:0]    keys_reg, keys_next;   // bit 0 = W, 1 = S, 2 = O, 3 = K
  logic [3:0]    hit;
  logic [TW-1:0] cnt_reg, cnt_next;
  logic          evt_reg, evt_next;
  logic [7:0]    code_reg, code_next;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_hit
      assign hit[gi] = (key_data == KEY_CODES[gi*8 +: 8]);
    end
  endgenerate

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    keys_next  = keys_reg;
    cnt_next   = cnt_reg;
    code_next  = code_reg;
    if (key_pressed) begin
      code_next = key_data;
      cnt_next  = '0;
      case (state_reg)
        IDLE: begin
          if (key_data == CODE_BRK)      state_next = BRK;
          else if (key_data == CODE_EXT) state_next = EXT;
          else                           keys_next  = keys_reg | hit;
        end
        BRK: begin
          if (key_data == CODE_EXT) state_next = EXT_BRK;
          else if (key_data != CODE_BRK) begin
            keys_next  = keys_reg & ~hit;
            state_next = IDLE;
          end
        end
        EXT:     state_next = (key_data == CODE_BRK) ? EXT_BRK : IDLE;
        default: state_next = IDLE;
      endcase
    end else if (TO_EN && (keys_reg != 4'b0000)) begin
      // Expiry only when no strobe arrives, so a strobe always wins the race.
      if (cnt_reg == TO_LAST) begin
        keys_next  = 4'b0000;
        state_next = IDLE;
        cnt_next   = '0;
      end else if (cnt_reg != TO_MAX) begin
        cnt_next = cnt_reg + TW'(1);
      end
    end else begin
      cnt_next = '0;
    end
    evt_next = (keys_next != keys_reg);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      keys_reg <= 4'b0000;
      cnt_reg  <= '0;
      evt_reg  <= 1'b0;
      code_reg <= 8'h00;
    end else begin
      keys_reg <= keys_next;
      cnt_reg  <= cnt_next;
      evt_reg  <= evt_next;
      code_reg <= code_next;
    end
  end

  assign w_on      = keys_reg[0];
  assign s_on      = keys_reg[1];
  assign o_on      = keys_reg[2];
  assign k_on      = keys_reg[3];
  assign key_evt   = evt_reg;
  assign last_code = code_reg;

endmodule

// File: tb/tb_ps2_paddle_keys.sv
// Self-checking bench for ps2_paddle_keys: directed scenarios plus randomized
// scancode streams against a prefix/key-set reference model (timeout = 100).
module tb_ps2_paddle_keys;

  localparam int TO = 100;

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic [7:0] key_data = 8'h00;
  logic       key_pressed = 1'b0;
  logic       w_on, s_on, o_on, k_on, key_evt;
  logic [7:0] last_code;

  int errors = 0;
  int checks = 0;

  // Reference model: set of held keys, pending break/extended prefixes,
  // and cycles elapsed since the last strobe.
  bit [3:0] m_keys;   // 0 = W, 1 = S, 2 = O, 3 = K
  bit       m_evt;
  bit [7:0] m_code;
  bit       m_brk, m_ext;
  int       m_idle;

  ps2_paddle_keys #(.TIMEOUT_CYC(TO), .TW(8)) dut (
    .clock(clock), .resetn(resetn), .key_data(key_data), .key_pressed(key_pressed),
    .w_on(w_on), .s_on(s_on), .o_on(o_on), .k_on(k_on),
    .key_evt(key_evt), .last_code(last_code)
  );

  always #5 clock = ~clock;

  function automatic logic [3:0] got_keys();
    return {k_on, o_on, s_on, w_on};
  endfunction

  function automatic int key_idx(input bit [7:0] b);
    case (b)
      8'h1D:   return 0;
      8'h1B:   return 1;
      8'h44:   return 2;
      8'h42:   return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_keys = '0; m_evt = 0; m_code = 8'h00; m_brk = 0; m_ext = 0; m_idle = 0;
  endtask

  task automatic model_update(input bit stb, input bit [7:0] b);
    bit [3:0] prev;
    int idx;
    prev = m_keys;
    idx  = key_idx(b);
    if (stb) begin
      m_code = b;
      m_idle = 0;
      if (m_ext && m_brk) begin
        m_ext = 0; m_brk = 0;
      end else if (m_ext) begin
        if (b == 8'hF0) m_brk = 1;
        else            m_ext = 0;
      end else if (m_brk) begin
        if (b == 8'hE0) m_ext = 1;
        else if (b != 8'hF0) begin
          if (idx >= 0) m_keys[idx] = 0;
          m_brk = 0;
        end
      end else begin
        if (b == 8'hF0)      m_brk = 1;
        else if (b == 8'hE0) m_ext = 1;
        else if (idx >= 0)   m_keys[idx] = 1;
      end
    end else if (m_keys != 0) begin
      m_idle++;
      if (m_idle >= TO) begin
        m_keys = '0; m_brk = 0; m_ext = 0; m_idle = 0;
      end
    end else begin
      m_idle = 0;
    end
    m_evt = (m_keys != prev);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic drive_cycle(input bit stb, input bit [7:0] b);
    key_pressed = stb;
    key_data    = b;
    model_update(stb, b);
    @(negedge clock);
    key_pressed = 1'b0;
  endtask

  task automatic send(input bit [7:0] b);
    drive_cycle(1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    key_pressed = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    resetn = 1'b0;
    model_reset();
    #1;
    checks++;
    if (got_keys() !== 4'b0000) begin errors++; $display("FAIL reset_keys: got %b want 0000", got_keys()); end
    checks++;
    if (key_evt !== 1'b0) begin errors++; $display("FAIL reset_evt: got %b want 0", key_evt); end
    checks++;
    if (last_code !== 8'h00) begin errors++; $display("FAIL reset_code: got %h want 00", last_code); end
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_make_break();
    do_reset();
    send(8'h1D);
    checks++;
    if (w_on !== 1'b1 || key_evt !== 1'b1) begin errors++; $display("FAIL make_w: got w=%b evt=%b want w=1 evt=1", w_on, key_evt); end
    checks++;
    if (last_code !== 8'h1D) begin errors++; $display("FAIL make_code: got %h want 1d", last_code); end
    send(8'hF0);
    checks++;
    if (w_on !== 1'b1 || key_evt !== 1'b0) begin errors++; $display("FAIL brk_prefix: got w=%b evt=%b want w=1 evt=0", w_on, key_evt); end
    send(8'h1D);
    checks++;
    if (w_on !== 1'b0 || key_evt !== 1'b1) begin errors++; $display("FAIL break_w: got w=%b evt=%b want w=0 evt=1", w_on, key_evt); end
    idle(1);
    checks++;
    if (key_evt !== 1'b0) begin errors++; $display("FAIL break_evt_once: got %b want 0", key_evt); end
    $display("test_make_break done");
  endtask

  task automatic test_independent();
    do_reset();
    send(8'h1D); send(8'h44); send(8'hF0); send(8'h1D);
    checks++;
    if (got_keys() !== 4'b0100) begin errors++; $display("FAIL indep_w_off: got %b want 0100", got_keys()); end
    send(8'hF0); send(8'h44);
    checks++;
    if (got_keys() !== 4'b0000 || key_evt !== 1'b1) begin errors++; $display("FAIL indep_o_off: got %b evt=%b want 0000 evt=1", got_keys(), key_evt); end
    $display("test_independent done");
  endtask

  task automatic test_typematic();
    int evts;
    do_reset();
    evts = 0;
    for (int i = 0; i < 5; i++) begin
      send(8'h1B);
      if (key_evt === 1'b1) evts++;
    end
    idle(1);
    checks++;
    if (s_on !== 1'b1 || evts != 1) begin errors++; $display("FAIL typematic: got s=%b evts=%0d want s=1 evts=1", s_on, evts); end
    $display("test_typematic done");
  endtask

  task automatic test_extended();
    do_reset();
    send(8'h1D);
    send(8'hE0); send(8'hF0); send(8'h1D);
    checks++;
    if (w_on !== 1'b1 || key_evt !== 1'b0) begin errors++; $display("FAIL ext_break: got w=%b evt=%b want w=1 evt=0", w_on, key_evt); end
    send(8'hE0); send(8'h1B);
    checks++;
    if (got_keys() !== 4'b0001) begin errors++; $display("FAIL ext_make: got %b want 0001", got_keys()); end
    send(8'h1B);
    checks++;
    if (got_keys() !== 4'b0011 || key_evt !== 1'b1) begin errors++; $display("FAIL ext_idle: got %b evt=%b want 0011 evt=1", got_keys(), key_evt); end
    $display("test_extended done");
  endtask

  task automatic test_timeout();
    do_reset();
    send(8'h42);
    idle(TO - 1);
    checks++;
    if (k_on !== 1'b1) begin errors++; $display("FAIL to_hold: got k=%b want 1", k_on); end
    idle(1);
    checks++;
    if (k_on !== 1'b0 || key_evt !== 1'b1) begin errors++; $display("FAIL to_clear: got k=%b evt=%b want k=0 evt=1", k_on, key_evt); end
    send(8'h42);
    idle(TO - 1);
    send(8'hAA);
    checks++;
    if (k_on !== 1'b1 || key_evt !== 1'b0) begin errors++; $display("FAIL to_race: got k=%b evt=%b want k=1 evt=0", k_on, key_evt); end
    idle(1);
    checks++;
    if (k_on !== 1'b1) begin errors++; $display("FAIL to_restart: got k=%b want 1", k_on); end
    $display("test_timeout done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(8'h1D);
    send(8'hF0);
    resetn = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({got_keys(), key_evt, last_code} !== 13'd0) begin errors++; $display("FAIL mid_reset: got keys=%b evt=%b code=%h want 0", got_keys(), key_evt, last_code); end
    repeat (2) @(negedge clock);
    checks++;
    if ({got_keys(), key_evt, last_code} !== 13'd0) begin errors++; $display("FAIL mid_reset_hold: got keys=%b evt=%b code=%h want 0", got_keys(), key_evt, last_code); end
    resetn = 1'b1;
    send(8'h1B);
    checks++;
    if (got_keys() !== 4'b0010 || key_evt !== 1'b1) begin errors++; $display("FAIL mid_reset_make: got %b evt=%b want 0010 evt=1", got_keys(), key_evt); end
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    bit [7:0] pool [10];
    int n, cyc;
    bit stb;
    bit [7:0] b;
    pool = '{8'h1D, 8'h1B, 8'h44, 8'h42, 8'hF0, 8'hF0, 8'hE0, 8'hAA, 8'hE1, 8'h00};
    do_reset();
    cyc = 0;
    for (int t = 0; t < 400; t++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: begin n = 1; stb = 1; end
        6, 7, 8:          begin n = $urandom_range(1, 5); stb = 0; end
        default:          begin n = $urandom_range(TO - 10, TO + 10); stb = 0; end
      endcase
      for (int i = 0; i < n; i++) begin
        b = pool[$urandom_range(0, 9)];
        if (b == 8'h00) b = 8'($urandom);
        drive_cycle(stb, b);
        cyc++;
        checks++;
        if (got_keys() !== m_keys) begin errors++; $display("FAIL rand_keys cyc %0d: got %b want %b", cyc, got_keys(), m_keys); end
        checks++;
        if (key_evt !== m_evt) begin errors++; $display("FAIL rand_evt cyc %0d: got %b want %b", cyc, key_evt, m_evt); end
        checks++;
        if (last_code !== m_code) begin errors++; $display("FAIL rand_code cyc %0d: got %h want %h", cyc, last_code, m_code); end
      end
    end
    $display("test_random done (%0d cycles)", cyc);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_make_break();
    test_independent();
    test_typematic();
    test_extended();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
